// File: rtl/serv_rf_serdes.sv
// serv_rf_serdes: fetches two register-file operands, streams them LSB-first to a bit-serial ALU and writes back the collected result
module serv_rf_serdes #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_go,
  input  logic [AW-1:0]    i_rs1_addr,
  input  logic [AW-1:0]    i_rs2_addr,
  input  logic [AW-1:0]    i_rd_addr,
  input  logic             i_rd_en,
  input  logic             i_rd,
  output logic             o_rs1,
  output logic             o_rs2,
  output logic             o_en,
  output logic             o_init,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rf_ren,
  output logic [AW-1:0]    o_rf_raddr,
  input  logic [WIDTH-1:0] i_rf_rdata,
  output logic             o_rf_wen,
  output logic [AW-1:0]    o_rf_waddr,
  output logic [WIDTH-1:0] o_rf_wdata
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, F1, F2, LD, RUN, WB} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic rd_en_q, rd_en_d;
  logic [WIDTH-1:0] sr1_q, sr1_d, sr2_q, sr2_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic take;
  assign take = (state_q == IDLE) && i_go;
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd_en_q <= 1'b0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd_en_q <= rd_en_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rs1_d   = take ? i_rs1_addr : rs1_q;
    rs2_d   = take ? i_rs2_addr : rs2_q;
    rd_d    = take ? i_rd_addr : rd_q;
    rd_en_d = take ? i_rd_en : rd_en_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = i_go ? F1 : IDLE;
      F1:   state_d = F2;
      F2: begin
        state_d = LD;
        sr1_d   = (rs1_q == '0) ? '0 : i_rf_rdata;
      end
      LD: begin
        state_d = RUN;
        sr2_d   = (rs2_q == '0) ? '0 : i_rf_rdata;
        cnt_d   = '0;
      end
      RUN: begin
        sr1_d   = {1'b0, sr1_q[WIDTH-1:1]};
        sr2_d   = {1'b0, sr2_q[WIDTH-1:1]};
        res_d   = {i_rd, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? WB : RUN;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_en       = state_q == RUN;
  assign o_rs1      = o_en & sr1_q[0];
  assign o_rs2      = o_en & sr2_q[0];
  assign o_init     = o_en && (cnt_q == '0);
  assign o_busy     = state_q != IDLE;
  assign o_done     = state_q == WB;
  assign o_rf_ren   = (state_q == F1) || (state_q == F2);
  assign o_rf_raddr = (state_q == F1) ? rs1_q : (state_q == F2) ? rs2_q : '0;
  assign o_rf_wen   = o_done && rd_en_q && (rd_q != '0);
  assign o_rf_waddr = o_done ? rd_q : '0;
  assign o_rf_wdata = o_done ? res_q : '0;
endmodule

// File: tb/tb_serv_rf_serdes.sv
// tb_serv_rf_serdes: table-driven bench with a register-file RAM model, serial ALU model and write-back scoreboard
module tb_serv_rf_serdes;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, rd_en = 1'b0, i_rd;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic o_rs1, o_rs2, o_en, o_init, o_busy, o_done, o_rf_ren, o_rf_wen;
  logic [4:0] o_rf_raddr, o_rf_waddr;
  logic [31:0] o_rf_wdata, rdata = '0;
  logic [31:0] mem [32];
  logic pre = 1'b1, mode = 1'b0, cy = 1'b0, cin;
  logic [49:0] outs;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic en, mode;
    logic [31:0] s1, s2;
    logic wen;
    logic [31:0] wdata;
  } vec_t;
  typedef struct {
    logic wen;
    logic [4:0] waddr;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];
  vec_t tbl [9];

  always #5 clk = ~clk;

  serv_rf_serdes dut (
    .clk(clk), .i_rst_n(rst_n), .i_go(go),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_en(rd_en), .i_rd(i_rd),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_en(o_en), .o_init(o_init), .o_busy(o_busy), .o_done(o_done),
    .o_rf_ren(o_rf_ren), .o_rf_raddr(o_rf_raddr), .i_rf_rdata(rdata),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
  );

  assign outs = {o_rs1, o_rs2, o_en, o_init, o_busy, o_done, o_rf_ren, o_rf_raddr, o_rf_wen, o_rf_waddr, o_rf_wdata};

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i) * 32'h0101_0101;
      mem[0]  <= 32'hFFFF_0000;
      mem[1]  <= 32'hFFFF_FFFF;
      mem[2]  <= 32'h0000_0001;
      mem[5]  <= 32'hDEAD_BEEF;
      mem[8]  <= 32'h1234_5678;
      mem[9]  <= 32'h1111_1111;
      mem[10] <= 32'hA5A5_A5A5;
    end else if (o_rf_wen) mem[o_rf_waddr] <= o_rf_wdata;
    if (o_rf_ren) rdata <= mem[o_rf_raddr];
  end

  // Serial ALU: pass-through of rs1, or ripple adder whose carry restarts on o_init
  assign cin  = o_init ? 1'b0 : cy;
  assign i_rd = mode ? (o_rs1 ^ o_rs2 ^ cin) : o_rs1;
  always @(posedge clk) if (o_en) cy <= (o_rs1 & o_rs2) | (cin & (o_rs1 ^ o_rs2));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (o_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_wen", o_rf_wen, e.wen);
        if (e.wen) begin
          chk("wb_waddr", o_rf_waddr, e.waddr);
          chk("wb_wdata", o_rf_wdata, e.wdata);
        end
      end
    end
  end

  task automatic push(input logic wen, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.wen = wen; e.waddr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int en_n = 0, init_n = 0, init_c = -1, done_c = -1;
    logic [31:0] s1 = '0, s2 = '0;
    mode = v.mode; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; rd_en = v.en; go = 1'b1;
    push(v.wen, v.rd, v.wdata);
    for (int c = 1; c <= 37; c++) begin
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
      if (o_en) begin
        en_n++;
        if (c >= 4 && c <= 35) begin
          s1[c-4] = o_rs1;
          s2[c-4] = o_rs2;
        end
      end
      if (o_init) begin init_n++; init_c = c; end
      if (o_done) done_c = c;
    end
    chk($sformatf("v%0d_en_cycles", id), en_n, 32);
    chk($sformatf("v%0d_init_count", id), init_n, 1);
    chk($sformatf("v%0d_init_cycle", id), init_c, 4);
    chk($sformatf("v%0d_done_cycle", id), done_c, 36);
    chk($sformatf("v%0d_rs1_stream", id), s1, v.s1);
    chk($sformatf("v%0d_rs2_stream", id), s2, v.s2);
    chk($sformatf("v%0d_idle_after", id), o_busy, 0);
  endtask

  initial begin
    vec_t post;
    int en_n, init_n, done_n, first_d, last_d;
    tbl[0] = '{5'd5,  5'd0, 5'd7,  1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[1] = '{5'd1,  5'd2, 5'd3,  1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000};
    tbl[2] = '{5'd8,  5'd9, 5'd11, 1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h23456789};
    tbl[3] = '{5'd5,  5'd9, 5'd0,  1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 1'b0, 32'h0};
    tbl[4] = '{5'd10, 5'd9, 5'd4,  1'b0, 1'b0, 32'hA5A5A5A5, 32'h11111111, 1'b0, 32'h0};
    tbl[5] = '{5'd0,  5'd9, 5'd12, 1'b1, 1'b1, 32'h0,        32'h11111111, 1'b1, 32'h11111111};
    tbl[6] = '{5'd7,  5'd0, 5'd13, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[7] = '{5'd4,  5'd0, 5'd15, 1'b1, 1'b0, 32'h04040404, 32'h0,        1'b1, 32'h04040404};
    tbl[8] = '{5'd11, 5'd3, 5'd14, 1'b1, 1'b1, 32'h23456789, 32'h0,        1'b1, 32'h23456789};
    repeat (2) @(negedge clk);
    pre = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle_outs_%0d", i), outs, 0);
    end
    for (int i = 0; i < 9; i++) run_txn(tbl[i], i);
    // i_go held high: back-to-back transactions every 37 cycles
    mode = 1'b0; rs1 = 5'd5; rs2 = 5'd2; rd = 5'd14; rd_en = 1'b1; go = 1'b1;
    for (int k = 0; k < 3; k++) push(1'b1, 5'd14, 32'hDEADBEEF);
    en_n = 0; init_n = 0; done_n = 0; first_d = -1; last_d = -1;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_en) en_n++;
      if (o_init) init_n++;
      if (o_done) begin
        done_n++;
        if (first_d < 0) first_d = c;
        last_d = c;
      end
    end
    go = 1'b0;
    chk("cont_en_cycles", en_n, 96);
    chk("cont_init_count", init_n, 3);
    chk("cont_done_count", done_n, 3);
    chk("cont_first_done", first_d, 36);
    chk("cont_last_done", last_d, 110);
    @(posedge clk);
    @(negedge clk);
    chk("cont_idle_after", o_busy, 0);
    // reset in the middle of RUN aborts without write-back
    mode = 1'b1; rs1 = 5'd8; rs2 = 5'd9; rd = 5'd15; rd_en = 1'b1; go = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      go = 1'b0;
    end
    chk("mid_run_en", o_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", outs, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold_outs_%0d", i), outs, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", outs, 0);
    post = '{5'd8, 5'd9, 5'd15, 1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h23456789};
    run_txn(post, 9);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
